uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Transmit-side buffer for the UART. It mirrors the RX circular buffer in the opposite direction.
//  MMIO pushes bytes at CPU speed. The block drains them one at a time into the UART core,
//  using the core's tx_ena/tx_data/tx_busy handshake. It sits between mmio_peripherals and the
//  UART core, so firmware never has to poll tx_busy for every byte.
// PARAMETERS
//  DATA_WIDTH    8   width of each FIFO entry and of uart_tx_data
//  ADDR_BITS     8   log2 of FIFO depth (depth = 2**ADDR_BITS = 256)
//  BUSY_TIMEOUT  16  max cycles to wait for uart_tx_busy to rise after a launch (must be >= 2)
// PORTS
//  clk           in   1             system clock (50 MHz)
//  reset         in   1             synchronous, active-high reset
//  clear         in   1             flush FIFO contents (synchronous, one-cycle pulse)
//  wr_en         in   1             push wr_data; ignored while full
//  wr_data       in   DATA_WIDTH    byte to queue
//  full          out  1             count == 2**ADDR_BITS
//  empty         out  1             count == 0
//  count         out  ADDR_BITS+1   bytes queued; excludes the byte in flight
//  uart_tx_ena   out  1             one-cycle launch strobe to the UART core
//  uart_tx_data  out  DATA_WIDTH    byte being sent; registered, held stable until next launch
//  uart_tx_busy  in   1             UART core transmitter busy
//  tx_idle       out  1             FIFO empty AND FSM in IDLE AND !uart_tx_busy
//  overflow      out  1             sticky dropped-write flag (see CONFIGURATION)
//  high_water    out  ADDR_BITS+1   peak count seen since reset/clear (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset=1 at a clk edge): clears all state.
//   - rd_ptr = wr_ptr = count = 0; FSM enters IDLE.
//   - uart_tx_ena = 0, uart_tx_data = 0, overflow = 0, high_water = 0.
//   - Resulting flags: empty = 1, full = 0, tx_idle = 1 once busy is low.
//   - Reset mid-transfer abandons the byte and never re-launches it.
//  Storage: circular array.
//   - Pointers are ADDR_BITS wide and wrap modulo depth with no special case.
//   - full and empty are derived combinationally from the registered count.
//  Push:
//   - wr_en && !full -> write mem[wr_ptr]; wr_ptr++.
//   - wr_en && full  -> write dropped; no pointer or count change.
//   - full is judged on the current-cycle value, even if a pop occurs in the same cycle.
//  Simultaneous push and pop: count is unchanged and both pointers advance.
//  FSM states:
//   - IDLE: if !empty && !uart_tx_busy:
//       uart_tx_data <= mem[rd_ptr]; rd_ptr++; count--; go to LAUNCH.
//   - LAUNCH: uart_tx_ena = 1 for exactly this cycle; timeout counter <= 0; go to WAIT_BUSY.
//   - WAIT_BUSY:
//       uart_tx_busy = 1 -> WAIT_DONE.
//       Counter reaches BUSY_TIMEOUT-1 -> IDLE; the byte is treated as sent, no retry.
//   - WAIT_DONE: uart_tx_busy = 0 -> IDLE.
//  Latency: a push at edge N into an empty FIFO with the core idle gives:
//   - empty = 0 after edge N;
//   - pop at edge N+1;
//   - uart_tx_ena high for the cycle after edge N+2.
//  Back-to-back throughput: one byte per UART frame, plus 2 cycles of FSM overhead.
//  clear:
//   - Sets rd_ptr = wr_ptr = 0 and count = 0; any same-cycle push is dropped.
//   - The byte already in LAUNCH/WAIT_* completes normally.
//   - clear has no effect on the FSM.
//  Wrap-around: after 2**ADDR_BITS pushes and pops, the pointers roll to 0 and ordering stays FIFO.
//  Width rule: count stays in [0, 2**ADDR_BITS]; it can never underflow because pop requires !empty.
// CONFIGURATION
//  UART_TX_FIFO_STATS_EN defined:
//   - overflow sets on any dropped push (wr_en && full) and clears only on reset or clear.
//   - high_water <= max(high_water, count) every cycle; it is reset by reset and by clear.
//  UART_TX_FIFO_STATS_EN undefined:
//   - overflow and high_water are tied to constant 0.
//   - No registers are inferred for them.
// TESTING
//  1. Reset held 2 cycles -> empty=1, full=0, count=0, uart_tx_ena=0, uart_tx_data=0, tx_idle=1.
//  2. Push 0x55, busy model rises 1 cycle after ena and stays high 10 cycles ->
//     ena pulses once with data 0x55, 2 cycles after the push edge; tx_idle=1 after busy falls.
//  3. Push 256 bytes 0x00..0xFF with busy held high -> full=1, count=256.
//     A 257th push (0xAA) is dropped; overflow=1 and high_water=256 when STATS_EN is defined.
//     Release busy -> output sequence is exactly 0x00..0xFF; 0xAA is never sent.
//  4. Core never asserts busy after a launch ->
//     FSM returns to IDLE after BUSY_TIMEOUT=16 cycles and launches the next queued byte.
//  5. Push 0x11, 0x22, 0x33; pulse clear while 0x11 is in WAIT_DONE ->
//     0x11 completes; 0x22 and 0x33 are never sent; count=0; high_water=0.
//  6. Wrap: stream 600 bytes with random wr_en, pushing only while !full ->
//     scoreboard shows in-order, lossless delivery; count returns to 0.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - transmit byte FIFO that drains into the UART core via tx_ena/tx_data/tx_busy
// Optional overflow/high_water statistics are built when UART_TX_FIFO_STATS_EN is defined.

module uart_tx_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_BITS    = 8,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_BITS:0]    count,
    output logic                  uart_tx_ena,
    output logic [DATA_WIDTH-1:0] uart_tx_data,
    input  logic                  uart_tx_busy,
    output logic                  tx_idle,
    output logic                  overflow,
    output logic [ADDR_BITS:0]    high_water
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int TW    = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;

    localparam logic [ADDR_BITS:0]   DEPTH_C  = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_BITS:0]   CNT_ONE  = (ADDR_BITS + 1)'(1);
    localparam logic [ADDR_BITS-1:0] PTR_ONE  = ADDR_BITS'(1);
    localparam logic [TW-1:0]        TMO_ONE  = TW'(1);
    localparam logic [TW-1:0]        TMO_LAST = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_BITS-1:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0]    rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    tx_ena_q, tx_ena_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic push;
    logic pop;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // A push in the same cycle as clear is discarded along with the flushed contents.
    assign push = wr_en && !full && !clear;

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        tx_ena_d  = 1'b0;
        tmo_d     = tmo_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty && !uart_tx_busy) begin
                    pop       = 1'b1;
                    tx_data_d = mem_q[rd_ptr_q];
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                tx_ena_d = 1'b1;
                tmo_d    = '0;
                state_d  = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (uart_tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    // Core never acknowledged: drop the byte rather than stall the queue.
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end
            S_WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            tx_data_q <= '0;
            tx_ena_q  <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            tx_data_q <= tx_data_d;
            tx_ena_q  <= tx_ena_d;
            tmo_q     <= tmo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign count        = count_q;
    assign uart_tx_ena  = tx_ena_q;
    assign uart_tx_data = tx_data_q;
    assign tx_idle      = empty && (state_q == S_IDLE) && !uart_tx_busy;

`ifdef UART_TX_FIFO_STATS_EN
    logic                 overflow_q, overflow_d;
    logic [ADDR_BITS:0]   high_water_q, high_water_d;

    always_comb begin
        overflow_d   = overflow_q | (wr_en && full);
        high_water_d = (count_q > high_water_q) ? count_q : high_water_q;
        if (clear) begin
            overflow_d   = 1'b0;
            high_water_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q   <= 1'b0;
            high_water_q <= '0;
        end else begin
            overflow_q   <= overflow_d;
            high_water_q <= high_water_d;
        end
    end

    assign overflow   = overflow_q;
    assign high_water = high_water_q;
`else
    assign overflow   = 1'b0;
    assign high_water = '0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo with a behavioural UART core busy model

module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [8:0] count;
    logic       uart_tx_ena;
    logic [7:0] uart_tx_data;
    logic       uart_tx_busy;
    logic       tx_idle;
    logic       overflow;
    logic [8:0] high_water;

    logic busy_gen;
    logic busy_hold;
    logic busy_never;
    logic busy_arm;
    int   busy_len;
    int   busy_left;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] sb_exp;

    assign uart_tx_busy = busy_gen | busy_hold;

    uart_tx_fifo #(
        .DATA_WIDTH  (8),
        .ADDR_BITS   (8),
        .BUSY_TIMEOUT(16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .uart_tx_ena (uart_tx_ena),
        .uart_tx_data(uart_tx_data),
        .uart_tx_busy(uart_tx_busy),
        .tx_idle     (tx_idle),
        .overflow    (overflow),
        .high_water  (high_water)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int maxc, input string nm);
        int c;
        c = 0;
        while (!(tx_idle && exp_q.size() == 0) && c < maxc) begin
            tick();
            c++;
        end
        check(nm, 32'(tx_idle && exp_q.size() == 0), 32'd1);
    endtask

    // UART core model: busy rises one cycle after a launch strobe and stays high busy_len cycles.
    initial begin
        busy_gen  = 1'b0;
        busy_arm  = 1'b0;
        busy_left = 0;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                busy_gen = 1'b0;
                busy_arm = 1'b0;
            end else begin
                if (busy_gen) begin
                    busy_left--;
                    if (busy_left <= 0) busy_gen = 1'b0;
                end else if (busy_arm) begin
                    busy_arm  = 1'b0;
                    busy_gen  = 1'b1;
                    busy_left = busy_len;
                end
                if (uart_tx_ena === 1'b1 && !busy_never) busy_arm = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b0 && uart_tx_ena === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: launched 0x%0h, required no launch", uart_tx_data);
            end else begin
                sb_exp = exp_q.pop_front();
                check("sb_data", 32'(uart_tx_data), 32'(sb_exp));
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int pushed;
        reset      = 1'b1;
        clear      = 1'b0;
        wr_en      = 1'b0;
        wr_data    = 8'h00;
        busy_hold  = 1'b0;
        busy_never = 1'b0;
        busy_len   = 10;

        // 1. reset state
        tick();
        tick();
        reset = 1'b0;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ena", 32'(uart_tx_ena), 32'd0);
        check("rst_data", 32'(uart_tx_data), 32'd0);
        check("rst_tx_idle", 32'(tx_idle), 32'd1);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_high_water", 32'(high_water), 32'd0);

        // 2. single byte latency
        wr_en   = 1'b1;
        wr_data = 8'h55;
        exp_q.push_back(8'h55);
        tick();
        wr_en = 1'b0;
        check("t2_empty_after_push", 32'(empty), 32'd0);
        check("t2_count_after_push", 32'(count), 32'd1);
        tick();
        check("t2_ena_n1", 32'(uart_tx_ena), 32'd0);
        check("t2_count_after_pop", 32'(count), 32'd0);
        tick();
        check("t2_ena_n2", 32'(uart_tx_ena), 32'd1);
        check("t2_data_n2", 32'(uart_tx_data), 32'h55);
        tick();
        check("t2_ena_single", 32'(uart_tx_ena), 32'd0);
        check("t2_tx_idle_busy", 32'(tx_idle), 32'd0);
        wait_drain(60, "t2_drain");
        check("t2_data_held", 32'(uart_tx_data), 32'h55);

        // 3. fill to full with the core held busy, then drop one push
        busy_hold = 1'b1;
        for (int i = 0; i < 256; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i);
            exp_q.push_back(8'(i));
            tick();
        end
        check("t3_full", 32'(full), 32'd1);
        check("t3_count", 32'(count), 32'd256);
        wr_data = 8'hAA;
        tick();
        wr_en = 1'b0;
        check("t3_count_after_drop", 32'(count), 32'd256);
`ifdef UART_TX_FIFO_STATS_EN
        check("t3_overflow", 32'(overflow), 32'd1);
        check("t3_high_water", 32'(high_water), 32'd256);
`else
        check("t3_overflow", 32'(overflow), 32'd0);
        check("t3_high_water", 32'(high_water), 32'd0);
`endif
        busy_len  = 2;
        busy_hold = 1'b0;
        wait_drain(6000, "t3_drain");
        check("t3_count_final", 32'(count), 32'd0);

        // 4. busy timeout: core never acknowledges
        busy_never = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h12;
        exp_q.push_back(8'h12);
        tick();
        wr_data = 8'h34;
        exp_q.push_back(8'h34);
        tick();
        wr_en = 1'b0;
        c = 0;
        while (uart_tx_ena !== 1'b1 && c < 10) begin
            tick();
            c++;
        end
        check("t4_first_launch", 32'(uart_tx_ena), 32'd1);
        c = 0;
        do begin
            tick();
            c++;
        end while (uart_tx_ena !== 1'b1 && c < 40);
        check("t4_launch_gap", 32'(c), 32'd18);
        busy_never = 1'b0;
        wait_drain(100, "t4_drain");

        // 5. clear while the first byte is in WAIT_DONE
        busy_len = 10;
        wr_en   = 1'b1;
        wr_data = 8'h11;
        exp_q.push_back(8'h11);
        tick();
        wr_data = 8'h22;
        tick();
        wr_data = 8'h33;
        tick();
        wr_en = 1'b0;
        c = 0;
        while (uart_tx_busy !== 1'b1 && c < 20) begin
            tick();
            c++;
        end
        check("t5_busy_seen", 32'(uart_tx_busy), 32'd1);
        tick();
        tick();
        check("t5_count_before_clear", 32'(count), 32'd2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t5_count_after_clear", 32'(count), 32'd0);
        check("t5_empty_after_clear", 32'(empty), 32'd1);
        check("t5_overflow_after_clear", 32'(overflow), 32'd0);
        tick();
        check("t5_high_water_after_clear", 32'(high_water), 32'd0);
        wait_drain(60, "t5_drain");
        for (int i = 0; i < 20; i++) tick();
        check("t5_count_final", 32'(count), 32'd0);

        // 6. 600-byte stream with random push gaps, crosses pointer wrap
        busy_len = 1;
        pushed   = 0;
        c        = 0;
        while (pushed < 600 && c < 20000) begin
            wr_en = ($urandom_range(0, 1) == 1) && !full;
            if (wr_en) begin
                wr_data = 8'($urandom_range(0, 255));
                exp_q.push_back(wr_data);
                pushed++;
            end
            tick();
            c++;
        end
        wr_en = 1'b0;
        check("t6_pushed", 32'(pushed), 32'd600);
        wait_drain(20000, "t6_drain");
        check("t6_count_final", 32'(count), 32'd0);
        check("t6_empty_final", 32'(empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
